sawtooth_gen_param: RTL and testbench

Parametrised successor to the fixed-width sawtooth counter. It loads two bounds (N1, N2) through a single strobe button and starts/pauses with a start button. On every divided tick it steps a counter between the bounds in one of three latched modes: up-sawtooth, down-sawtooth or triangle. It sits between the board buttons/switches and the LED/seven-segment display logic, with a configurable step and a clock divider.

---
 rtl/sawtooth_gen_param.sv | 246 ++++++++++++++++++++++++
 tb/tb_sawtooth_gen_param.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/sawtooth_gen_param.sv
// sawtooth_gen_param
//   Button-driven waveform counter. Two bounds are loaded through the v_i
//   button. st_i starts and pauses the run. On every divided tick, cnt steps
//   between min(N1,N2) and max(N1,N2). It can run as an up-sawtooth, a
//   down-sawtooth or a triangle.
//
// Parameters
//   W    data width of bounds, step and counter
//   DIV  clocks per tick (>= 2)
//
// Ports
//   clk_i    system clock
//   rst_i    asynchronous active-low reset
//   v_i      load/advance button (asynchronous level, edge acts)
//   st_i     start/pause button (asynchronous level, edge acts)
//   din_i    bound value, taken on a v edge in LOAD_N1/LOAD_N2
//   step_i   step size, taken at RUN entry (0 means 1)
//   mode_i   00 up-saw, 01 down-saw, 10 triangle, 11 up-saw; taken at RUN entry
//   cnt_o    counter value
//   n1_o     stored bound N1
//   n2_o     stored bound N2
//   state_o  FSM state code
//   tick_o   one-clock pulse in the cycle whose closing edge applies a tick
//   wrap_o   one-clock pulse after a tick that wrapped / returned to lo
module sawtooth_gen_param #(
  parameter int W   = 8,
  parameter int DIV = 12_500_000
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         v_i,
  input  logic         st_i,
  input  logic [W-1:0] din_i,
  input  logic [W-1:0] step_i,
  input  logic [1:0]   mode_i,
  output logic [W-1:0] cnt_o,
  output logic [W-1:0] n1_o,
  output logic [W-1:0] n2_o,
  output logic [2:0]   state_o,
  output logic         tick_o,
  output logic         wrap_o
);

  localparam int            DW       = $clog2(DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD_N1 = 3'd1,
    S_LOAD_N2 = 3'd2,
    S_READY   = 3'd3,
    S_RUN     = 3'd4,
    S_PAUSE   = 3'd5
  } state_t;

  state_t        state_reg, state_next;

  // Bit 0 is the metastability flop, bit 1 is the synchronised level, and
  // bit 2 is the delayed copy used for rising-edge detection.
  logic [2:0]    v_sync_reg, st_sync_reg;
  logic          v_rise, st_rise;

  logic [W-1:0]  n1_reg, n2_reg, cnt_reg, step_reg;
  logic [1:0]    mode_reg;
  logic          dir_down_reg;
  logic [DW-1:0] div_reg;
  logic          wrap_reg;

  logic [W-1:0]  lo, hi;

  // FSM control strobes
  logic          load_n1, load_n2, run_init, div_run, tick_fire;

  // tick arithmetic results
  logic [W-1:0]  cnt_next;
  logic          dir_next, wrap_next;
  logic [W:0]    cnt_ext, step_ext, lo_ext, hi_ext, up_sum, lo_plus, down_diff;

  // ---------------- button synchronisers ----------------
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      v_sync_reg  <= '0;
      st_sync_reg <= '0;
    end else begin
      v_sync_reg  <= {v_sync_reg[1:0], v_i};
      st_sync_reg <= {st_sync_reg[1:0], st_i};
    end
  end

  assign v_rise  = v_sync_reg[1]  & ~v_sync_reg[2];
  assign st_rise = st_sync_reg[1] & ~st_sync_reg[2];

  assign lo = (n1_reg < n2_reg) ? n1_reg : n2_reg;
  assign hi = (n1_reg < n2_reg) ? n2_reg : n1_reg;

  // ---------------- FSM ----------------
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_reg <= S_IDLE;
    else        state_reg <= state_next;
  end

  // If both buttons have an edge in the same cycle, v wins in states where
  // v does something. Otherwise st acts. A pause edge that lands on the
  // terminal divider count blocks that tick, so the frozen cnt/divider
  // match what was on the outputs.
  always_comb begin
    state_next = state_reg;
    load_n1    = 1'b0;
    load_n2    = 1'b0;
    run_init   = 1'b0;
    div_run    = 1'b0;
    tick_fire  = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (v_rise) state_next = S_LOAD_N1;
      end
      S_LOAD_N1: begin
        if (v_rise) begin
          load_n1    = 1'b1;
          state_next = S_LOAD_N2;
        end
      end
      S_LOAD_N2: begin
        if (v_rise) begin
          load_n2    = 1'b1;
          state_next = S_READY;
        end
      end
      S_READY: begin
        if (v_rise) begin
          state_next = S_LOAD_N1;
        end else if (st_rise) begin
          state_next = S_RUN;
          run_init   = 1'b1;
        end
      end
      S_RUN: begin
        if (st_rise) begin
          state_next = S_PAUSE;
        end else begin
          div_run   = 1'b1;
          tick_fire = (div_reg == DIV_LAST);
        end
      end
      S_PAUSE: begin
        if (v_rise)       state_next = S_LOAD_N1;
        else if (st_rise) state_next = S_RUN;
      end
      default: state_next = S_IDLE;  // codes 6 and 7
    endcase
  end

  // ---------------- tick arithmetic (one bit wider than the data) ----------------
  assign cnt_ext   = {1'b0, cnt_reg};
  assign step_ext  = {1'b0, step_reg};
  assign lo_ext    = {1'b0, lo};
  assign hi_ext    = {1'b0, hi};
  assign up_sum    = cnt_ext + step_ext;
  assign lo_plus   = lo_ext + step_ext;
  assign down_diff = cnt_ext - step_ext;

  always_comb begin
    cnt_next  = cnt_reg;
    dir_next  = dir_down_reg;
    wrap_next = 1'b0;
    case (mode_reg)
      2'b01: begin
        if (cnt_ext < lo_plus) begin
          cnt_next  = hi;
          wrap_next = 1'b1;
        end else begin
          cnt_next = down_diff[W-1:0];
        end
      end
      2'b10: begin
        if (!dir_down_reg) begin
          if (up_sum >= hi_ext) begin
            cnt_next = hi;
            dir_next = 1'b1;
          end else begin
            cnt_next = up_sum[W-1:0];
          end
        end else begin
          // The first term guards the subtraction against underflow.
          if ((cnt_ext < lo_plus) || (down_diff <= lo_ext)) begin
            cnt_next  = lo;
            dir_next  = 1'b0;
            wrap_next = 1'b1;
          end else begin
            cnt_next = down_diff[W-1:0];
          end
        end
      end
      default: begin  // 00 and 11: up-sawtooth
        if (up_sum > hi_ext) begin
          cnt_next  = lo;
          wrap_next = 1'b1;
        end else begin
          cnt_next = up_sum[W-1:0];
        end
      end
    endcase
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      n1_reg       <= '0;
      n2_reg       <= '0;
      cnt_reg      <= '0;
      step_reg     <= W'(1);
      mode_reg     <= 2'b00;
      dir_down_reg <= 1'b0;
      div_reg      <= '0;
      wrap_reg     <= 1'b0;
    end else begin
      wrap_reg <= 1'b0;
      if (load_n1) n1_reg <= din_i;
      if (load_n2) n2_reg <= din_i;
      if (run_init) begin
        mode_reg     <= mode_i;
        step_reg     <= (step_i == '0) ? W'(1) : step_i;
        div_reg      <= '0;
        dir_down_reg <= 1'b0;
        cnt_reg      <= (mode_i == 2'b01) ? hi : lo;
      end else if (div_run) begin
        if (tick_fire) begin
          div_reg      <= '0;
          cnt_reg      <= cnt_next;
          dir_down_reg <= dir_next;
          wrap_reg     <= wrap_next;
        end else begin
          div_reg <= div_reg + DW'(1);
        end
      end
    end
  end

  assign cnt_o   = cnt_reg;
  assign n1_o    = n1_reg;
  assign n2_o    = n2_reg;
  assign state_o = state_reg;
  assign tick_o  = tick_fire;
  assign wrap_o  = wrap_reg;

endmodule

// File: tb/tb_sawtooth_gen_param.sv
// Directed testbench for sawtooth_gen_param with W=8, DIV=4.
// DUT outputs are sampled on the falling clock edge. Inputs change on the
// falling clock edge.
module tb_sawtooth_gen_param;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       v_i, st_i;
  logic [7:0] din_i, step_i;
  logic [1:0] mode_i;
  logic [7:0] cnt_o, n1_o, n2_o;
  logic [2:0] state_o;
  logic       tick_o, wrap_o;

  int n_compared   = 0;
  int n_mismatched = 0;

  sawtooth_gen_param #(.W(8), .DIV(4)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .v_i     (v_i),
    .st_i    (st_i),
    .din_i   (din_i),
    .step_i  (step_i),
    .mode_i  (mode_i),
    .cnt_o   (cnt_o),
    .n1_o    (n1_o),
    .n2_o    (n2_o),
    .state_o (state_o),
    .tick_o  (tick_o),
    .wrap_o  (wrap_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end else begin
      $display("ok   %s: %0d", tag, obs);
    end
  endtask

  // Pulses the selected buttons for one clock. Then it waits until the
  // synchronised edge has acted. This is 3 falling edges after the set.
  task automatic press(input logic pv, input logic ps);
    v_i  = pv;
    st_i = ps;
    @(negedge clk_i);
    v_i  = 1'b0;
    st_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
  endtask

  // Covers one divided tick period, starting just after divider = 0.
  task automatic step_tick(input logic [7:0] exp_cnt, input logic exp_wrap, input string tag);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_i);
      check_value({tag, " tick low"}, tick_o, 0);
      check_value({tag, " wrap low"}, wrap_o, 0);
    end
    @(negedge clk_i);
    check_value({tag, " tick high"}, tick_o, 1);
    @(negedge clk_i);
    check_value({tag, " cnt"}, cnt_o, exp_cnt);
    check_value({tag, " wrap"}, wrap_o, exp_wrap);
    check_value({tag, " tick after"}, tick_o, 0);
  endtask

  initial begin
    logic [7:0] up_seq [6];
    logic [7:0] dn_seq [4];
    logic [7:0] tr_seq [7];
    logic       tick_seen;
    logic [2:0] prev_state;
    int         transitions;

    up_seq = '{8'd25, 8'd30, 8'd35, 8'd40, 8'd20, 8'd25};
    dn_seq = '{8'd56, 8'd36, 8'd16, 8'd76};
    tr_seq = '{8'd14, 8'd18, 8'd20, 8'd16, 8'd12, 8'd10, 8'd14};

    rst_i  = 1'b0;
    v_i    = 1'b0;
    st_i   = 1'b0;
    din_i  = 8'd0;
    step_i = 8'd0;
    mode_i = 2'b00;
    repeat (3) @(negedge clk_i);
    rst_i = 1'b1;
    check_value("reset state", state_o, 0);
    check_value("reset cnt", cnt_o, 0);
    check_value("reset n1", n1_o, 0);
    check_value("reset n2", n2_o, 0);
    check_value("reset tick", tick_o, 0);
    check_value("reset wrap", wrap_o, 0);

    // Up-saw run that is reset asynchronously when cnt = 30.
    press(1, 0);
    din_i = 8'd20; press(1, 0);
    din_i = 8'd40; press(1, 0);
    mode_i = 2'b00; step_i = 8'd5; press(0, 1);
    check_value("pre-reset cnt entry", cnt_o, 20);
    step_tick(8'd25, 0, "pre-reset t1");
    step_tick(8'd30, 0, "pre-reset t2");
    #2 rst_i = 1'b0;
    #1;
    check_value("async rst state", state_o, 0);
    check_value("async rst cnt", cnt_o, 0);
    check_value("async rst n1", n1_o, 0);
    check_value("async rst n2", n2_o, 0);
    check_value("async rst tick", tick_o, 0);
    check_value("async rst wrap", wrap_o, 0);
    @(negedge clk_i);
    rst_i = 1'b1;

    // After reset, the first v edge only leaves IDLE.
    din_i = 8'd99; press(1, 0);
    check_value("idle->load_n1 state", state_o, 1);
    check_value("idle->load_n1 n1", n1_o, 0);
    din_i = 8'd20; press(1, 0);
    check_value("load n1 state", state_o, 2);
    check_value("load n1 value", n1_o, 20);
    din_i = 8'd40; press(1, 0);
    check_value("load n2 state", state_o, 3);
    check_value("load n2 value", n2_o, 40);
    mode_i = 2'b00; step_i = 8'd5; press(0, 1);
    check_value("up run state", state_o, 4);
    check_value("up cnt entry", cnt_o, 20);
    for (int i = 0; i < 6; i++)
      step_tick(up_seq[i], (i == 4), $sformatf("up t%0d", i + 1));

    // Pause freezes cnt and divider.
    press(0, 1);
    check_value("pause state", state_o, 5);
    check_value("pause cnt", cnt_o, 25);
    tick_seen = 1'b0;
    repeat (20) begin
      @(negedge clk_i);
      tick_seen = tick_seen | tick_o;
    end
    check_value("pause cnt held", cnt_o, 25);
    check_value("pause no tick", tick_seen, 0);
    check_value("pause state held", state_o, 5);
    // Pause acted at divider = 2, so one clock of divider count remains.
    press(0, 1);
    check_value("resume state", state_o, 4);
    @(negedge clk_i);
    check_value("resume tick", tick_o, 1);
    @(negedge clk_i);
    check_value("resume cnt", cnt_o, 30);

    // A v edge in PAUSE leads into a down-saw load.
    press(0, 1);
    check_value("pause2 state", state_o, 5);
    din_i = 8'd76; press(1, 0);
    check_value("pause v state", state_o, 1);
    check_value("pause v cnt held", cnt_o, 30);
    press(1, 0);
    check_value("dn n1", n1_o, 76);
    din_i = 8'd15; press(1, 0);
    check_value("dn n2", n2_o, 15);
    check_value("dn ready cnt held", cnt_o, 30);
    mode_i = 2'b01; step_i = 8'd20; press(0, 1);
    check_value("dn cnt entry", cnt_o, 76);
    for (int i = 0; i < 4; i++)
      step_tick(dn_seq[i], (i == 3), $sformatf("dn t%0d", i + 1));

    // Simultaneous v and st in PAUSE: v wins.
    press(0, 1);
    press(1, 1);
    check_value("simul v+st state", state_o, 1);
    din_i = 8'd10; press(1, 0);
    din_i = 8'd20; press(1, 0);
    mode_i = 2'b10; step_i = 8'd4; press(0, 1);
    check_value("tri cnt entry", cnt_o, 10);
    for (int i = 0; i < 7; i++)
      step_tick(tr_seq[i], (i == 5), $sformatf("tri t%0d", i + 1));

    // Triangle with step 0 is latched as 1.
    press(0, 1);
    press(1, 0);
    din_i = 8'd10; press(1, 0);
    din_i = 8'd20; press(1, 0);
    step_i = 8'd0; press(0, 1);
    check_value("step0 cnt entry", cnt_o, 10);
    step_tick(8'd11, 0, "step0 t1");
    step_tick(8'd12, 0, "step0 t2");

    // A held st button acts only once.
    prev_state  = state_o;
    transitions = 0;
    st_i = 1'b1;
    repeat (50) begin
      @(negedge clk_i);
      if (state_o != prev_state) transitions++;
      prev_state = state_o;
    end
    st_i = 1'b0;
    check_value("held st transitions", transitions, 1);
    check_value("held st state", state_o, 5);
    check_value("held st cnt", cnt_o, 12);

    // v toggled 3 clocks apart gives two transitions, each 2 edges later.
    din_i = 8'd55;
    v_i = 1'b1;
    @(negedge clk_i); v_i = 1'b0;
    @(negedge clk_i);
    check_value("toggle1 +1 edge", state_o, 5);
    @(negedge clk_i);
    check_value("toggle1 +2 edges", state_o, 1);
    v_i = 1'b1;
    @(negedge clk_i); v_i = 1'b0;
    @(negedge clk_i);
    check_value("toggle2 +1 edge", state_o, 1);
    @(negedge clk_i);
    check_value("toggle2 +2 edges", state_o, 2);
    check_value("toggle2 n1", n1_o, 55);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
